mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: MulOp  input  4  operation code: 0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MADD, 0101 MADDU, 0110 MSUB, 0111 MSUBU, 1000 none; 1001-1111 treated as none.
REQ-004 SHALL have port: MTHILO  input  2  move-to: 00 write LO, 01 write HI, 10/11 none.
REQ-005 SHALL have port: MFHILO  input  2  move-from select: 01 LO, 10 HI, 00/11 zero.
REQ-006 SHALL have port: flush  input  1  current E-stage instruction cancelled (exception or interrupt); suppresses start and moves.
REQ-007 SHALL have port: A  input  32  rs operand.
REQ-008 SHALL have port: B  input  32  rt operand.
REQ-009 SHALL have port: busy  output  1  registered; high while an operation is in flight.
REQ-010 SHALL have port: HI  output  32  current HI register.
REQ-011 SHALL have port: LO  output  32  current LO register.
REQ-012 SHALL have port: rdata  output  32  combinational move-from result per MFHILO.

Function
REQ-013 A start SHALL occur at a rising edge where MulOp is 0000-0111, busy=0 and flush=0; A and B are captured at that edge.
REQ-014 MulOp valid while busy=1 SHALL be ignored; the pipeline stalls on (busy OR MulOp valid).
REQ-015 The state machine SHALL have states IDLE, MUL, DIV; IDLE->MUL on MULT/MULTU/MADD*/MSUB* start, IDLE->DIV on DIV/DIVU start, MUL/DIV->IDLE when the counter expires.
REQ-016 After a start at edge k, busy SHALL be 1 from edge k through edge k+4 (MUL) or k+9 (DIV), and SHALL be 0 after edge k+5 (MUL) or k+10 (DIV).
REQ-017 HI/LO SHALL update exactly at the edge where busy falls; they SHALL hold their prior values while busy=1.
REQ-018 MULT/MULTU SHALL set {HI,LO} to the 64-bit signed/unsigned product of A and B.
REQ-019 MADD/MADDU SHALL set {HI,LO} = {HI,LO} + product, and MSUB/MSUBU SHALL set {HI,LO} = {HI,LO} - product, in 64-bit modulo 2^64 arithmetic, using the HI/LO values current at completion.
REQ-020 DIV SHALL set LO to the quotient truncated toward zero and HI to the remainder carrying the dividend's sign; DIVU SHALL set LO/HI to the unsigned quotient/remainder.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-022 Divide by zero (B=0) SHALL still take 10 cycles of busy and SHALL leave HI and LO unchanged.
REQ-023 MTHILO write SHALL occur at the edge when busy=0 and flush=0, loading A into the selected register; it is ignored while busy=1.
REQ-024 If a start and an MTHILO write arrive in the same cycle, the start SHALL take effect and the move SHALL be ignored (decoder never produces both).
REQ-025 rdata SHALL reflect the register values current in the same cycle (no bypass of an in-flight result).
REQ-026 flush SHALL NOT abort an operation already in flight; it affects only the operation or move presented in the same cycle.

Reset
REQ-027 On reset assertion, HI, LO and busy SHALL become 0 and the state SHALL become IDLE asynchronously, including mid-operation; the in-flight result SHALL be discarded.
REQ-028 The first start SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-029 MULT with A=0xFFFFFFFE (-2), B=0x00000003 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 DIV with A=0xFFFFFFF9 (-7), B=0x00000002 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with A=7, B=0 after HI=0x11, LO=0x22 -> HI/LO stay 0x11/0x22.
REQ-031 MTHI A=0xFFFFFFFF, MTLO A=0xFFFFFFFF, then MADDU with A=1, B=1 -> HI=0x00000000, LO=0x00000000 (wrap); followed by MSUB with A=1, B=1 -> HI=LO=0xFFFFFFFF.
REQ-032 Present MULT with flush=1 -> busy stays 0 and HI/LO are unchanged; present MTLO during busy -> LO is unchanged.
REQ-033 Assert reset at cycle 3 of a DIV -> busy=0 and HI=LO=0 immediately, with no later HI/LO update.
REQ-034 With MFHILO=10, 01 and 00 -> rdata equals HI, LO and 0x00000000 respectively in the same cycle.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle integer multiply/divide unit with HI/LO result registers.
// Multiplies complete 5 cycles after start, divides 10; HI/LO change only at completion.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MulOp,
  input  logic [1:0]  MTHILO,
  input  logic [1:0]  MFHILO,
  input  logic        flush,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam logic [3:0] MUL_LAST = 4'd4;
  localparam logic [3:0] DIV_LAST = 4'd9;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [2:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [63:0] mres_r;
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic        div_zero_r;

  logic        start_s;
  logic        start_div_s;
  logic        op_signed_s;
  logic [63:0] ext_a_s;
  logic [63:0] ext_b_s;
  logic [63:0] prod_s;
  logic [63:0] mul_res_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] uquo_s;
  logic [31:0] urem_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  function automatic logic [31:0] neg_if(input logic c, input logic [31:0] v);
    neg_if = c ? (~v + 32'd1) : v;
  endfunction

  // Start decode: a valid opcode is taken only when idle and not cancelled.
  always_comb begin
    start_s     = (MulOp[3] == 1'b0) && (busy == 1'b0) && (flush == 1'b0);
    start_div_s = (MulOp[3:1] == 3'b001);
  end

  // Multiplier: sign-extend to 64 bits so one unsigned multiply serves both signednesses.
  always_comb begin
    op_signed_s = ~op_r[0];
    ext_a_s     = {{32{op_signed_s & a_r[31]}}, a_r};
    ext_b_s     = {{32{op_signed_s & b_r[31]}}, b_r};
    prod_s      = ext_a_s * ext_b_s;
    case (op_r[2:1])
      2'b10:   mul_res_s = {HI, LO} + mres_r;
      2'b11:   mul_res_s = {HI, LO} - mres_r;
      default: mul_res_s = mres_r;
    endcase
  end

  // Divider on magnitudes; quotient sign is the XOR of operand signs, remainder follows dividend.
  always_comb begin
    a_neg_s = op_signed_s & a_r[31];
    b_neg_s = op_signed_s & b_r[31];
    mag_a_s = neg_if(a_neg_s, a_r);
    mag_b_s = neg_if(b_neg_s, b_r);
    if (mag_b_s == 32'd0) begin
      uquo_s = 32'd0;
      urem_s = 32'd0;
    end else begin
      uquo_s = mag_a_s / mag_b_s;
      urem_s = mag_a_s % mag_b_s;
    end
    quo_s = neg_if(a_neg_s ^ b_neg_s, uquo_s);
    rem_s = neg_if(a_neg_s, urem_s);
  end

  // Move-from read port; shows architectural HI/LO only, never an in-flight result.
  always_comb begin
    case (MFHILO)
      2'b01:   rdata = LO;
      2'b10:   rdata = HI;
      default: rdata = 32'd0;
    endcase
  end

  // Datapath pipeline: results settle one cycle after capture and are held until completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mres_r     <= 64'd0;
      quo_r      <= 32'd0;
      rem_r      <= 32'd0;
      div_zero_r <= 1'b0;
    end else if (busy) begin
      mres_r     <= prod_s;
      quo_r      <= quo_s;
      rem_r      <= rem_s;
      div_zero_r <= (b_r == 32'd0);
    end else begin
      mres_r     <= mres_r;
      quo_r      <= quo_r;
      rem_r      <= rem_r;
      div_zero_r <= div_zero_r;
    end
  end

  // Control FSM with registered busy and HI/LO architectural state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      busy    <= 1'b0;
      op_r    <= 3'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            a_r  <= A;
            b_r  <= B;
            op_r <= MulOp[2:0];
            busy <= 1'b1;
            if (start_div_s) begin
              state_r <= DIV;
              cnt_r   <= DIV_LAST;
            end else begin
              state_r <= MUL;
              cnt_r   <= MUL_LAST;
            end
          end else if (flush == 1'b0) begin
            case (MTHILO)
              2'b00:   LO <= A;
              2'b01:   HI <= A;
              default: ;
            endcase
          end else begin
            busy <= 1'b0;
          end
        end
        MUL: begin
          if (cnt_r == 4'd0) begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            {HI, LO} <= mul_res_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DIV: begin
          if (cnt_r == 4'd0) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            // Divide by zero consumes the full latency but leaves HI/LO untouched.
            if (!div_zero_r) begin
              HI <= rem_r;
              LO <= quo_r;
            end else begin
              HI <= HI;
              LO <= LO;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

endmodule
